// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
//   state_t     : controller FSM states (3-bit encoding)
//   FWD_*       : operand forwarding select encodings
//   X0          : architectural zero register address
//   fwd_select  : forwarding select for one source operand (EX beats WB)
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_LOAD_STALL = 3'd1,
    ST_REDIRECT   = 3'd2,
    ST_MEM_WAIT   = 3'd3,
    ST_HALT       = 3'd4
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  localparam logic [4:0] X0 = 5'd0;

  // Width of the memory-wait timeout counter (covers MEM_TIMEOUT up to 65535).
  localparam int unsigned TMO_W = 16;

  // A load in EX has no result yet, so it never forwards from EX.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_ex,
    input logic       wr_ex,
    input logic       ld_ex,
    input logic [4:0] rd_wb,
    input logic       wr_wb
  );
    if (wr_ex && (rd_ex != X0) && (rd_ex == rs) && !ld_ex)
      return FWD_EX;
    else if (wr_wb && (rd_wb != X0) && (rd_wb == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Stateless hazard detection and operand forwarding.
//   rs1_ID/rs2_ID, use_rs1_ID/use_rs2_ID : ID source operands and their use flags
//   rd_EX, WrEn_RF_EX, is_load_EX        : EX destination, write enable, load flag
//   rd_WB, WrEn_RF_WB                    : WB destination and write enable
//   fwd_a_sel/fwd_b_sel                  : operand source selects (RF / EX / WB)
//   load_use                             : ID consumes the result of the load in EX
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       use_rs1_ID,
  input  logic       use_rs2_ID,
  input  logic [4:0] rd_EX,
  input  logic       WrEn_RF_EX,
  input  logic       is_load_EX,
  input  logic [4:0] rd_WB,
  input  logic       WrEn_RF_WB,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       load_use
);

  always_comb begin
    fwd_a_sel = fwd_select(rs1_ID, rd_EX, WrEn_RF_EX, is_load_EX, rd_WB, WrEn_RF_WB);
    fwd_b_sel = fwd_select(rs2_ID, rd_EX, WrEn_RF_EX, is_load_EX, rd_WB, WrEn_RF_WB);
  end

  always_comb begin
    load_use = is_load_EX && WrEn_RF_EX && (rd_EX != X0) &&
               ((use_rs1_ID && (rd_EX == rs1_ID)) ||
                (use_rs2_ID && (rd_EX == rs2_ID)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the ID/EX/WB pipeline register banks and the PC.
// Drives bank enables and bubble flushes, forwarding selects, and handles
// load-use stalls, EX redirects, data-memory waits with timeout and halt.
//   clk, rst_n                          : clock, synchronous active-low reset
//   rs*/use_rs*_ID                      : ID operand addresses and use flags
//   rd_EX, WrEn_RF_EX, is_load_EX       : EX destination info
//   rd_WB, WrEn_RF_WB                   : WB destination info
//   PC_Mux_EX                           : EX redirect (taken branch/jump)
//   dm_req_EX, dm_ack                   : data memory request / completion
//   halt_req_EX                         : tohost write with nonzero data
//   pc_en, ifid_en, idex_en, exwb_en    : register bank enables
//   ifid_flush, idex_flush, exwb_flush  : load a bubble into the bank
//   fwd_a_sel, fwd_b_sel                : 00 RF, 01 EX result, 10 WB result
//   halted, mem_err                     : halt status, sticky memory timeout
//   stall_cycles                        : saturating count of PC-stalled cycles
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_BUBBLES = 2,
  parameter int unsigned MEM_TIMEOUT      = 255,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             WrEn_RF_EX,
  input  logic             is_load_EX,
  input  logic [4:0]       rd_WB,
  input  logic             WrEn_RF_WB,
  input  logic             PC_Mux_EX,
  input  logic             dm_req_EX,
  input  logic             dm_ack,
  input  logic             halt_req_EX,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exwb_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [2:0]     RCNT_INIT = 3'(REDIRECT_BUBBLES - 1);
  localparam logic [TMO_W:0] TMO_LIMIT = 17'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [2:0]       rcnt, rcnt_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic [TMO_W:0]   tmo_inc;
  logic             err_nxt;
  logic             run_eval;
  logic             in_redirect;
  logic [1:0]       sel_a, sel_b;
  logic             load_use;

  hazard_fwd_unit u_hazard_fwd_unit (
    .rs1_ID     (rs1_ID),
    .rs2_ID     (rs2_ID),
    .use_rs1_ID (use_rs1_ID),
    .use_rs2_ID (use_rs2_ID),
    .rd_EX      (rd_EX),
    .WrEn_RF_EX (WrEn_RF_EX),
    .is_load_EX (is_load_EX),
    .rd_WB      (rd_WB),
    .WrEn_RF_WB (WrEn_RF_WB),
    .fwd_a_sel  (sel_a),
    .fwd_b_sel  (sel_b),
    .load_use   (load_use)
  );

  assign fwd_a_sel = rst_n ? sel_a : FWD_RF;
  assign fwd_b_sel = rst_n ? sel_b : FWD_RF;

  assign tmo_inc = {1'b0, tmo_cnt} + 17'd1;

  // Control decode and next state. RUN, LOAD_STALL, REDIRECT and the MEM_WAIT
  // ack cycle share one priority evaluation; REDIRECT only adds the forced IF/ID
  // flush and ignores load-use, since its ID stage holds a squashed slot.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exwb_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exwb_flush  = 1'b0;
    state_nxt   = state;
    rcnt_nxt    = rcnt;
    tmo_nxt     = tmo_cnt;
    err_nxt     = mem_err;
    run_eval    = 1'b0;
    in_redirect = (state == ST_REDIRECT);

    unique case (state)
      ST_RUN, ST_LOAD_STALL, ST_REDIRECT: run_eval = 1'b1;
      ST_MEM_WAIT: begin
        if (dm_ack) begin
          run_eval = 1'b1;
        end else begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_en = 1'b0;
          exwb_en = 1'b0;
          if (tmo_inc == TMO_LIMIT) begin
            state_nxt = ST_HALT;
            err_nxt   = 1'b1;
          end else begin
            tmo_nxt = tmo_inc[TMO_W-1:0];
          end
        end
      end
      ST_HALT: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        exwb_en = 1'b0;
      end
      default: state_nxt = ST_RUN;
    endcase

    if (run_eval) begin
      state_nxt = ST_RUN;
      if (in_redirect && (rcnt != 3'd1)) begin
        state_nxt = ST_REDIRECT;
        rcnt_nxt  = rcnt - 3'd1;
      end

      // The entry cycle already counts as the first wait cycle.
      if ((state != ST_MEM_WAIT) && dm_req_EX && !dm_ack) begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        exwb_en = 1'b0;
        tmo_nxt = 16'd1;
        if (TMO_LIMIT == 17'd1) begin
          state_nxt = ST_HALT;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = ST_MEM_WAIT;
        end
      end else if (halt_req_EX) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b1;
        state_nxt  = ST_HALT;
      end else if (PC_Mux_EX) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (REDIRECT_BUBBLES > 1) begin
          state_nxt = ST_REDIRECT;
          rcnt_nxt  = RCNT_INIT;
        end else begin
          state_nxt = ST_RUN;
        end
      end else if (load_use && !in_redirect) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        state_nxt  = ST_LOAD_STALL;
      end

      if (in_redirect) ifid_flush = 1'b1;
    end

    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exwb_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exwb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      rcnt         <= '0;
      tmo_cnt      <= '0;
      mem_err      <= 1'b0;
      halted       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state   <= state_nxt;
      rcnt    <= rcnt_nxt;
      tmo_cnt <= tmo_nxt;
      mem_err <= err_nxt;
      halted  <= (state_nxt == ST_HALT);
      if (!pc_en && (state != ST_HALT) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

  localparam int BUB   = 2;
  localparam int TMO   = 8;
  localparam int CW    = 5;
  localparam int SMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1_ID, rs2_ID, rd_EX, rd_WB;
  logic          use_rs1_ID, use_rs2_ID, WrEn_RF_EX, is_load_EX, WrEn_RF_WB;
  logic          PC_Mux_EX, dm_req_EX, dm_ack, halt_req_EX;
  logic          pc_en, ifid_en, idex_en, exwb_en;
  logic          ifid_flush, idex_flush, exwb_flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          halted, mem_err;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: halt flag, error flag, wait cycles elapsed (0 = not
  // waiting), remaining extra IF/ID bubbles, and the stall count.
  bit       m_halt = 0, m_err = 0;
  int       m_wait = 0, m_bub = 0, m_stall = 0;
  bit       n_halt, n_err;
  int       n_wait, n_bub, n_stall;
  logic [3:0] exp_en;
  logic [2:0] exp_fl;
  logic [1:0] exp_fa, exp_fb;

  pipeline_hazard_ctrl #(
    .REDIRECT_BUBBLES(BUB),
    .MEM_TIMEOUT     (TMO),
    .CNT_W           (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_ID       (rs1_ID),
    .rs2_ID       (rs2_ID),
    .use_rs1_ID   (use_rs1_ID),
    .use_rs2_ID   (use_rs2_ID),
    .rd_EX        (rd_EX),
    .WrEn_RF_EX   (WrEn_RF_EX),
    .is_load_EX   (is_load_EX),
    .rd_WB        (rd_WB),
    .WrEn_RF_WB   (WrEn_RF_WB),
    .PC_Mux_EX    (PC_Mux_EX),
    .dm_req_EX    (dm_req_EX),
    .dm_ack       (dm_ack),
    .halt_req_EX  (halt_req_EX),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exwb_en      (exwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exwb_flush   (exwb_flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .halted       (halted),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (WrEn_RF_EX && rd_EX != 0 && rd_EX == rs && !is_load_EX) return 2'b01;
    if (WrEn_RF_WB && rd_WB != 0 && rd_WB == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic eval_model();
    bit lu, redir;
    lu = is_load_EX && WrEn_RF_EX && rd_EX != 0 &&
         ((use_rs1_ID && rd_EX == rs1_ID) || (use_rs2_ID && rd_EX == rs2_ID));
    exp_fa  = ref_fwd(rs1_ID);
    exp_fb  = ref_fwd(rs2_ID);
    n_halt  = m_halt;
    n_err   = m_err;
    n_wait  = 0;
    n_bub   = 0;
    n_stall = m_stall;
    if (!rst_n) begin
      exp_en = 4'b0000; exp_fl = 3'b111; exp_fa = 2'b00; exp_fb = 2'b00;
      n_halt = 0; n_err = 0; n_stall = 0;
      return;
    end
    exp_en = 4'b1111;
    exp_fl = 3'b000;
    if (m_halt) begin
      exp_en = 4'b0000;
    end else if (m_wait > 0 && !dm_ack) begin
      exp_en = 4'b0000;
      if (m_wait + 1 >= TMO) begin n_halt = 1; n_err = 1; end
      else n_wait = m_wait + 1;
    end else begin
      redir = (m_bub > 0);
      if (redir) n_bub = m_bub - 1;
      if (m_wait == 0 && dm_req_EX && !dm_ack) begin
        exp_en = 4'b0000;
        n_bub  = 0;
        if (TMO == 1) begin n_halt = 1; n_err = 1; end
        else n_wait = 1;
      end else if (halt_req_EX) begin
        exp_en = 4'b0001; exp_fl = 3'b010; n_bub = 0; n_halt = 1;
      end else if (PC_Mux_EX) begin
        exp_fl = 3'b110; n_bub = BUB - 1;
      end else if (lu && !redir) begin
        exp_en = 4'b0011; exp_fl = 3'b010;
      end
      if (redir) exp_fl[2] = 1'b1;
    end
    if (!m_halt && !exp_en[3] && n_stall < SMAX) n_stall++;
  endtask

  task automatic step();
    @(negedge clk);
    eval_model();
    chk("enables", {pc_en, ifid_en, idex_en, exwb_en}, exp_en);
    chk("flushes", {ifid_flush, idex_flush, exwb_flush}, exp_fl);
    chk("fwd_a",   fwd_a_sel, exp_fa);
    chk("fwd_b",   fwd_b_sel, exp_fb);
    chk("halted",  halted, m_halt);
    chk("mem_err", mem_err, m_err);
    chk("stall",   stall_cycles, m_stall);
    @(posedge clk);
    m_halt = n_halt; m_err = n_err; m_wait = n_wait; m_bub = n_bub; m_stall = n_stall;
    #1;
  endtask

  task automatic clr();
    rs1_ID = 0; rs2_ID = 0; rd_EX = 0; rd_WB = 0;
    use_rs1_ID = 0; use_rs2_ID = 0; WrEn_RF_EX = 0; is_load_EX = 0; WrEn_RF_WB = 0;
    PC_Mux_EX = 0; dm_req_EX = 0; dm_ack = 0; halt_req_EX = 0;
  endtask

  task automatic rand_inputs();
    rst_n       = ($urandom_range(0, 99) < (m_halt ? 25 : 2)) ? 1'b0 : 1'b1;
    rs1_ID      = 5'($urandom_range(0, 3));
    rs2_ID      = 5'($urandom_range(0, 3));
    rd_EX       = 5'($urandom_range(0, 3));
    rd_WB       = 5'($urandom_range(0, 3));
    use_rs1_ID  = 1'($urandom_range(0, 1));
    use_rs2_ID  = 1'($urandom_range(0, 1));
    WrEn_RF_EX  = ($urandom_range(0, 99) < 70);
    is_load_EX  = ($urandom_range(0, 99) < 30);
    WrEn_RF_WB  = ($urandom_range(0, 99) < 60);
    PC_Mux_EX   = ($urandom_range(0, 99) < 10);
    dm_req_EX   = ($urandom_range(0, 99) < 20);
    dm_ack      = ($urandom_range(0, 99) < 30);
    halt_req_EX = ($urandom_range(0, 99) < 2);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    @(posedge clk); #1;
    step(); step();
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall_cycles, 0);
    rst_n = 1'b1;

    // load x5 in EX, ID reads x5 -> one stall, then WB forwarding
    clr(); is_load_EX = 1; WrEn_RF_EX = 1; rd_EX = 5; rs1_ID = 5; use_rs1_ID = 1;
    step();
    clr(); rd_WB = 5; WrEn_RF_WB = 1; rs1_ID = 5; use_rs1_ID = 1;
    step();
    chk("lu_fwd_a", fwd_a_sel, 2'b10);
    chk("lu_stall_cnt", stall_cycles, 1);

    // ALU result forwarding from EX, and x0 never forwards
    clr(); WrEn_RF_EX = 1; rd_EX = 7; rs2_ID = 7; use_rs2_ID = 1;
    step();
    chk("alu_fwd_b", fwd_b_sel, 2'b01);
    chk("alu_no_stall", pc_en, 1);
    rd_EX = 0; rs2_ID = 0;
    step();
    chk("x0_fwd_b", fwd_b_sel, 2'b00);

    // redirect with a coincident load-use hazard
    clr(); PC_Mux_EX = 1; is_load_EX = 1; WrEn_RF_EX = 1; rd_EX = 3; rs1_ID = 3; use_rs1_ID = 1;
    step();
    clr();
    step(); step();

    // memory wait acknowledged after four stalled cycles
    clr(); dm_req_EX = 1;
    repeat (4) step();
    dm_ack = 1;
    step();
    chk("mw_stall", stall_cycles, 5);
    clr(); step();

    // memory timeout
    clr(); dm_req_EX = 1;
    repeat (10) step();
    chk("tmo_err", mem_err, 1);
    chk("tmo_halt", halted, 1);
    chk("tmo_stall", stall_cycles, 13);

    // reset clears the error halt
    clr(); rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    chk("clr_err", mem_err, 0);
    chk("clr_halt", halted, 0);

    // tohost halt
    halt_req_EX = 1; step();
    clr(); step(); step();
    chk("halt_flag", halted, 1);
    chk("halt_pc_en", pc_en, 0);
    rst_n = 1'b0; step();
    rst_n = 1'b1;

    repeat (4000) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
